// File: rtl/cpu_run_stat_if.sv
// CPU-facing bus of the run-control/statistics unit: advance strobe, halt handshake,
// event flags and counter readout. cpu_run_stat is the master side.
interface cpu_run_stat_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned NCH   = 3,
   parameter int unsigned SEL_W = $clog2(NCH + 1)
) ();
   logic             run_en;
   logic             halted;
   logic             halt_req;
   logic [NCH-1:0]   evt;
   logic             clr;
   logic [SEL_W-1:0] rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic [NCH:0]     ovf;

   modport master (
      output run_en, halted, rd_data, ovf,
      input  halt_req, evt, clr, rd_sel
   );

   modport slave (
      input  run_en, halted, rd_data, ovf,
      output halt_req, evt, clr, rd_sel
   );
endinterface

// File: rtl/cpu_run_stat.sv
// Run control (two-rate divider, single-step, halt/resume) producing a one-clock CPU
// advance strobe, plus retired-cycle and per-channel event counters with readout.
module cpu_run_stat #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned NCH      = 3,
   parameter int unsigned FAST_DIV = 0,
   parameter int unsigned SLOW_DIV = 1048575,
   parameter int unsigned SAT      = 1,
   parameter int unsigned SEL_W    = $clog2(NCH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           change_hz,
   input  logic           step_mode,
   input  logic           step_btn,
   input  logic           resume,
   cpu_run_stat_if.master bus
);
   localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
   localparam int unsigned DIV_W   = (MAX_DIV > 0) ? $clog2(MAX_DIV + 1) : 1;

   typedef enum logic [1:0] {StRun, StStep, StHalted} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d, cur_div;
   logic               run_en_q, run_en_d, halted_q;
   logic               step_q, resume_q, hz_q;
   logic               step_rise, resume_rise, halting, at_term;

   logic [NCH:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NCH:0]            ovf_q, ovf_d, inc;
   logic [CNT_W-1:0]        rd_q, rd_d;

   assign cur_div     = change_hz ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
   assign step_rise   = step_btn & ~step_q;
   assign resume_rise = resume & ~resume_q;
   assign halting     = run_en_q & bus.halt_req;
   assign at_term     = (div_q == cur_div);

   always_comb begin
      state_d = state_q;
      if (halting) begin
         state_d = StHalted;
      end else begin
         case (state_q)
            StRun:    if (step_mode) state_d = StStep;
            StStep:   if (!step_mode) state_d = StRun;
            StHalted: if (resume_rise) state_d = step_mode ? StStep : StRun;
            default:  state_d = StRun;
         endcase
      end
   end

   // The halting strobe is the last one, even when the divider is at terminal count.
   assign run_en_d = ~halting & (((state_q == StRun) & at_term) |
                                 ((state_q == StStep) & step_rise));

   assign div_d = ((state_q != StRun) || (change_hz != hz_q) || at_term) ? '0
                                                                          : div_q + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StRun;
         div_q    <= '0;
         run_en_q <= 1'b0;
         halted_q <= 1'b0;
         step_q   <= 1'b1;
         resume_q <= 1'b1;
         hz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         run_en_q <= run_en_d;
         halted_q <= (state_d == StHalted);
         step_q   <= step_btn;
         resume_q <= resume;
         hz_q     <= change_hz;
      end
   end

   // Bit 0 is the retired-cycle counter; bit k counts events on channel k-1.
   assign inc = {bus.evt & {NCH{run_en_q}}, run_en_q};

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus.clr) begin
         cnt_d = '0;
         ovf_d = '0;
      end else begin
         for (int unsigned k = 0; k <= NCH; k++) begin
            if (inc[k]) begin
               if (&cnt_q[k]) begin
                  ovf_d[k] = 1'b1;
                  cnt_d[k] = (SAT != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rd_d = '0;
      for (int unsigned k = 0; k <= NCH; k++) begin
         if (bus.rd_sel == SEL_W'(k)) rd_d = cnt_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         ovf_q <= '0;
         rd_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         rd_q  <= rd_d;
      end
   end

   assign bus.run_en  = run_en_q;
   assign bus.halted  = halted_q;
   assign bus.rd_data = rd_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_cpu_run_stat.sv
// Bench for cpu_run_stat: two instances (A: fast=1/slow=7/saturating, B: fast=0/slow=7/
// wrapping) share stimulus; a per-cycle behavioural model plus literal expectations.
module tb_cpu_run_stat;
   localparam int CW   = 4;
   localparam int NC   = 2;
   localparam int SW   = 2;
   localparam int MAXC = 15;
   localparam int M_RUN = 0, M_STEP = 1, M_HALT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          change_hz, step_mode, step_btn, resume, halt_req, clr;
   logic [NC-1:0] evt;
   logic [SW-1:0] rd_sel;

   int n_vec = 0;
   int n_err = 0;
   int sa = 0, sb = 0;

   cpu_run_stat_if #(.CNT_W(CW), .NCH(NC), .SEL_W(SW)) ia ();
   cpu_run_stat_if #(.CNT_W(CW), .NCH(NC), .SEL_W(SW)) ib ();

   assign ia.halt_req = halt_req;
   assign ia.evt      = evt;
   assign ia.clr      = clr;
   assign ia.rd_sel   = rd_sel;
   assign ib.halt_req = halt_req;
   assign ib.evt      = evt;
   assign ib.clr      = clr;
   assign ib.rd_sel   = rd_sel;

   cpu_run_stat #(.CNT_W(CW), .NCH(NC), .FAST_DIV(1), .SLOW_DIV(7), .SAT(1), .SEL_W(SW)) dut_a (
      .clk(clk), .rst(rst), .change_hz(change_hz), .step_mode(step_mode),
      .step_btn(step_btn), .resume(resume), .bus(ia.master)
   );

   cpu_run_stat #(.CNT_W(CW), .NCH(NC), .FAST_DIV(0), .SLOW_DIV(7), .SAT(0), .SEL_W(SW)) dut_b (
      .clk(clk), .rst(rst), .change_hz(change_hz), .step_mode(step_mode),
      .step_btn(step_btn), .resume(resume), .bus(ib.master)
   );

   always #5 clk = ~clk;

   // Model state per instance (0 = A, 1 = B).
   int       FD[2]  = '{1, 0};
   int       SD[2]  = '{7, 7};
   bit       SATV[2] = '{1'b1, 1'b0};
   int       m_mode[2], m_phase[2], m_rd[2];
   bit       m_ren[2], m_hlt[2], m_pstep[2], m_pres[2], m_phz[2];
   int       m_cnt[2][3];
   bit [2:0] m_ovf[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int d);
      m_mode[d]  = M_RUN;
      m_phase[d] = 0;
      m_ren[d]   = 1'b0;
      m_hlt[d]   = 1'b0;
      m_pstep[d] = 1'b1;
      m_pres[d]  = 1'b1;
      m_phz[d]   = 1'b0;
      m_rd[d]    = 0;
      m_ovf[d]   = '0;
      for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
   endtask

   task automatic model_tick(input int d);
      int per, mode_n, phase_n;
      bit srise, rrise, halting, ren_n, hit;
      per     = change_hz ? FD[d] : SD[d];
      srise   = step_btn && !m_pstep[d];
      rrise   = resume && !m_pres[d];
      halting = m_ren[d] && halt_req;
      m_rd[d] = (int'(rd_sel) <= NC) ? m_cnt[d][rd_sel] : 0;
      if (clr) begin
         for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
         m_ovf[d] = '0;
      end else if (m_ren[d]) begin
         for (int k = 0; k < 3; k++) begin
            hit = (k == 0) ? 1'b1 : evt[k-1];
            if (hit) begin
               if (m_cnt[d][k] == MAXC) begin
                  m_ovf[d][k]  = 1'b1;
                  m_cnt[d][k]  = SATV[d] ? MAXC : 0;
               end else begin
                  m_cnt[d][k]++;
               end
            end
         end
      end
      ren_n   = !halting && ((m_mode[d] == M_RUN && m_phase[d] == per) ||
                             (m_mode[d] == M_STEP && srise));
      phase_n = (m_mode[d] != M_RUN || change_hz != m_phz[d] || m_phase[d] == per)
                ? 0 : m_phase[d] + 1;
      mode_n  = m_mode[d];
      if (halting) mode_n = M_HALT;
      else if (m_mode[d] == M_HALT && rrise) mode_n = step_mode ? M_STEP : M_RUN;
      else if (m_mode[d] == M_RUN && step_mode) mode_n = M_STEP;
      else if (m_mode[d] == M_STEP && !step_mode) mode_n = M_RUN;
      m_ren[d]   = ren_n;
      m_phase[d] = phase_n;
      m_mode[d]  = mode_n;
      m_hlt[d]   = (mode_n == M_HALT);
      m_pstep[d] = step_btn;
      m_pres[d]  = resume;
      m_phz[d]   = change_hz;
   endtask

   // Model advances on each rising edge; DUT outputs are compared 1 time unit later.
   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst) model_reset(d);
            else model_tick(d);
         end
         #1;
         chk("a run_en",  ia.run_en,  m_ren[0]);
         chk("a halted",  ia.halted,  m_hlt[0]);
         chk("a rd_data", ia.rd_data, m_rd[0]);
         chk("a ovf",     ia.ovf,     m_ovf[0]);
         chk("b run_en",  ib.run_en,  m_ren[1]);
         chk("b halted",  ib.halted,  m_hlt[1]);
         chk("b rd_data", ib.rd_data, m_rd[1]);
         chk("b ovf",     ib.ovf,     m_ovf[1]);
         if (ia.run_en === 1'b1) sa++;
         if (ib.run_en === 1'b1) sb++;
      end
   end

   task automatic wait_strobe(input int d, input int lim, output int off);
      off = -1;
      for (int i = 1; i <= lim; i++) begin
         @(posedge clk);
         #1;
         if (((d == 0) ? ia.run_en : ib.run_en) === 1'b1) begin
            off = i;
            break;
         end
      end
   endtask

   task automatic press(input int hi, input int lo);
      @(negedge clk) step_btn = 1'b1;
      repeat (hi) @(negedge clk);
      step_btn = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      int off, sa0, sb0;
      change_hz = 1'b0; step_mode = 1'b0; step_btn = 1'b1; resume = 1'b1;
      halt_req = 1'b0; clr = 1'b0; evt = '0; rd_sel = '0;
      repeat (3) @(negedge clk);
      chk("reset run_en", ia.run_en, 0);
      chk("reset halted", ib.halted, 0);
      chk("reset rd_data", ia.rd_data, 0);
      chk("reset ovf", ib.ovf, 0);

      // Slow rate: first strobe 8 clocks after release, 5 strobes by edge 40.
      step_btn = 1'b0; resume = 1'b0; rst = 1'b1;
      wait_strobe(0, 20, off);
      chk("first slow strobe", off, 8);
      repeat (34) @(posedge clk);
      #1;
      chk("a cycles after 5", ia.rd_data, 5);
      chk("b cycles after 5", ib.rd_data, 5);

      // Rate switch with A's divider at 5.
      repeat (3) @(posedge clk);
      @(negedge clk) change_hz = 1'b1;
      wait_strobe(0, 10, off);
      chk("a strobe after switch", off, 3);
      wait_strobe(0, 10, off);
      chk("a fast period", off, 2);

      // Halt on B's 4th strobe after a clear.
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      repeat (3) @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk) halt_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("b halted", ib.halted, 1);
      chk("b run_en halted", ib.run_en, 0);
      chk("b halt cycles", ib.rd_data, 4);
      chk("a halted", ia.halted, 1);
      chk("a halt cycles", ia.rd_data, 2);
      @(negedge clk) resume = 1'b1;
      wait_strobe(1, 10, off);
      chk("b resume latency", off, 2);

      // Step button held through reset, then three presses.
      @(negedge clk);
      change_hz = 1'b0; step_mode = 1'b1; step_btn = 1'b1; resume = 1'b0; rst = 1'b0;
      sa0 = sa; sb0 = sb;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      step_btn = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) press(3, 3);
      repeat (2) @(negedge clk);
      chk("a step strobes", sa - sa0, 3);
      chk("b step strobes", sb - sb0, 3);

      // Channel 1 event on 17 strobes: saturate (A) vs wrap (B).
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      evt = 2'b10;
      for (int i = 0; i < 17; i++) press(2, 2);
      @(negedge clk) rd_sel = 2'd2;
      repeat (3) @(negedge clk);
      chk("a ch1 sat", ia.rd_data, 15);
      chk("b ch1 wrap", ib.rd_data, 1);
      chk("a ovf", ia.ovf, 3'b101);
      chk("b ovf", ib.ovf, 3'b101);
      rd_sel = 2'd0;
      repeat (2) @(negedge clk);
      chk("a cycles sat", ia.rd_data, 15);
      chk("b cycles wrap", ib.rd_data, 1);
      rd_sel = 2'd3;
      repeat (2) @(negedge clk);
      chk("a sel out of range", ia.rd_data, 0);
      chk("b sel out of range", ib.rd_data, 0);

      // Clear in the same cycle as a strobe.
      @(negedge clk) step_btn = 1'b1;
      @(negedge clk) clr = 1'b1;
      @(negedge clk) begin clr = 1'b0; step_btn = 1'b0; rd_sel = 2'd2; end
      repeat (2) @(negedge clk);
      chk("a clr ch1", ia.rd_data, 0);
      chk("a clr ovf", ia.ovf, 0);
      chk("b clr ovf", ib.ovf, 0);

      // Randomised traffic, including mid-run resets.
      step_mode = 1'b0; evt = '0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 49) == 0) change_hz = ~change_hz;
         if ($urandom_range(0, 59) == 0) step_mode = ~step_mode;
         if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
         if ($urandom_range(0, 19) == 0) resume = ~resume;
         halt_req = ($urandom_range(0, 9) == 0);
         clr      = ($urandom_range(0, 39) == 0);
         evt      = NC'($urandom);
         rd_sel   = SW'($urandom);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cpu_run_stat.md
# cpu_run_stat

Run-control and statistics unit for the MIPS CPU top. Replaces the free-running derived CPU clock with a single-clock `run_en` strobe (two selectable rates, single-step, halt-on-syscall/resume) and counts retired cycles plus NCH per-instruction event classes (unconditional jumps, conditional branches, taken branches, …) for the seven-segment display. Sits between the board buttons, the CPU datapath (all CPU state registers qualify on `run_en`) and `show_signal`.

## Interface
- CNT_W, 32, width of every statistic counter
- NCH, 3, number of event channels
- FAST_DIV, 0, terminal count for the fast rate; period FAST_DIV+1 clocks
- SLOW_DIV, 1048575, terminal count for the slow rate; period SLOW_DIV+1 clocks
- SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
- SEL_W, $clog2(NCH+1), width of `rd_sel`
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- change_hz  in  1  1 = FAST_DIV, 0 = SLOW_DIV
- step_mode  in  1  1 = advance only on `step_btn` rising edges
- step_btn  in  1  debounced step button, level
- halt_req  in  1  CPU executing a halting syscall; sampled only when `run_en`=1
- resume  in  1  debounced resume button, level
- evt  in  NCH  per-channel event flags from the current instruction; sampled only when `run_en`=1
- clr  in  1  synchronous clear of counters and overflow flags
- rd_sel  in  SEL_W  0 = cycle counter, k = channel k-1 (1..NCH)
- run_en  out  1  one-clock CPU advance strobe (registered)
- halted  out  1  1 while in HALTED
- rd_data  out  CNT_W  registered counter readout
- ovf  out  NCH+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1

## Operation
- States: RUN, STEP, HALTED. Reset state RUN.
- RUN → STEP when `step_mode`=1; STEP → RUN when `step_mode`=0 (checked every clock, not while HALTED).
- RUN/STEP → HALTED at the edge where `run_en`=1 and `halt_req`=1; the halting instruction commits (that strobe is the last one).
- HALTED → STEP (`step_mode`=1) or RUN (`step_mode`=0) on a `resume` rising edge.
- Divider `div_cnt` (width to hold max(FAST_DIV,SLOW_DIV)) counts 0..cur_div in RUN, then wraps to 0; held at 0 in STEP/HALTED; forced to 0 in any cycle `change_hz` differs from its previous-cycle value.
- `run_en` next value = 1 iff not (`run_en` and `halt_req`) and ((RUN and `div_cnt`==cur_div) or (STEP and `step_btn` rising edge)). Exactly one strobe per step edge.
- Edge detectors: previous-value registers for `step_btn`, `resume` reset to 1 (button held through reset never triggers); for `change_hz` reset to 0.
- Counters: cycle counter +1 per `run_en`; channel k +1 when `run_en` and `evt[k]`. On increment from all-ones: SAT=1 holds all-ones, SAT=0 wraps to 0; either way sets the matching `ovf` bit (sticky).
- `clr` zeroes all counters and `ovf`; `clr` wins over a same-cycle increment. `clr` does not affect state or divider.
- `rd_data` ← selected counter; `rd_sel` > NCH → 0.

## Timing
- Reset values: `run_en`=0, `halted`=0, `rd_data`=0, `ovf`=0, all counters 0, `div_cnt`=0.
- Reset asserted mid-operation: everything returns to reset values immediately (async); a strobe in flight is dropped.
- RUN, fixed rate: first `run_en` in clock cur_div+1 after reset release (counting release cycle as 0), then every cur_div+1 clocks. FAST_DIV=0 ⇒ `run_en` continuously 1.
- Step: `run_en` high in the clock after the edge where the `step_btn` rise was sampled.
- Halt: `halted`=1 from the clock after the halting strobe; `run_en`=0 from that same clock even when cur_div=0.
- Counter update visible one clock after the strobe; `rd_data` one further clock (2-clock event-to-readout, 1-clock `rd_sel`-to-readout).

## Test plan
- CNT_W=4, FAST_DIV=1, SLOW_DIV=7, `change_hz`=0, release reset → `run_en` pulses every 8 clocks; after 5 pulses `rd_sel`=0 gives `rd_data`=5.
- Switch `change_hz` 0→1 mid-count at `div_cnt`=5 → divider restarts, next pulse 2 clocks later, then every 2 clocks.
- FAST_DIV=0, `halt_req`=1 on 4th strobe → exactly 4 strobes, `halted`=1, cycle count 4; `resume` rise → strobes resume next-but-one clock.
- `step_mode`=1, `step_btn` held through reset then released and pressed 3× → exactly 3 single-clock strobes.
- SAT=1, `evt[1]`=1 every strobe for 17 strobes → channel 1 reads 15, `ovf[2]`=1; SAT=0 → reads 1, `ovf[2]`=1; then `clr` coinciding with a strobe → reads 0, `ovf`=0.
- `rd_sel`=NCH+1 → `rd_data`=0.
